// File: rtl/uart_host_bridge_pkg.sv
// Purpose: shared protocol constants, opcodes and FSM state types for the host-side UART bridge.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package uart_host_bridge_pkg;

    // Frame header bytes on the wire
    localparam logic [7:0] HDR_ADS      = 8'hAA;  // ADS sample frame
    localparam logic [7:0] HDR_ADS_REG  = 8'h61;  // 'a' ADS register read / read-back
    localparam logic [7:0] HDR_MPR_REG  = 8'h6D;  // 'm' MPR register read / read-back
    localparam logic [7:0] HDR_RUN      = 8'h52;  // 'R'
    localparam logic [7:0] HDR_STOP     = 8'h93;  // 'S' as the sensor firmware encodes it

    // Payload lengths following a header
    localparam logic [2:0] LEN_ADS      = 3'd6;
    localparam logic [2:0] LEN_REG      = 3'd2;

    typedef enum logic [1:0] {
        OP_RUN    = 2'd0,
        OP_STOP   = 2'd1,
        OP_MPR_RD = 2'd2,
        OP_ADS_RD = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SEND_HDR,
        TX_WAIT_HDR,
        TX_SEND_ADDR,
        TX_WAIT_ADDR
    } tx_state_e;

    typedef enum logic {
        PS_HUNT,
        PS_COLLECT
    } ps_state_e;

    function automatic logic [7:0] op_header(input cmd_op_e op);
        logic [7:0] hdr;
        case (op)
            OP_RUN:    hdr = HDR_RUN;
            OP_STOP:   hdr = HDR_STOP;
            OP_MPR_RD: hdr = HDR_MPR_REG;
            default:   hdr = HDR_ADS_REG;
        endcase
        return hdr;
    endfunction

    // Register reads carry an address byte after the header
    function automatic logic op_has_addr(input cmd_op_e op);
        return (op == OP_MPR_RD) || (op == OP_ADS_RD);
    endfunction

endpackage

// File: rtl/uart_frame_parser.sv
// Purpose: reassembles sensor frames (0xAA+6, 'a'/'m'+2) from received bytes; byte in, frame + err pulse out.
// Latency: frame valid pulses the cycle after the last payload byte; err pulses the cycle after the fault.
// Backpressure: none; outputs hold until the next complete frame.
module uart_frame_parser
    import uart_host_bridge_pkg::*;
#(
    parameter int P_TIMEOUT_CLKS = 21700
) (
    input  logic        i_CLK,
    input  logic        i_RSTN,
    input  logic        i_RX_DV,
    input  logic [7:0]  i_RX_BYTE,
    output logic [47:0] o_ADS_DATA,
    output logic        o_ADS_VALID,
    output logic [15:0] o_REG_DATA,
    output logic        o_REG_SRC,
    output logic        o_REG_VALID,
    output logic        o_ERR_PULSE
);
    localparam logic [15:0] TMO_LAST = 16'(P_TIMEOUT_CLKS - 1);

    ps_state_e   r_state;
    logic [2:0]  r_need;
    logic [2:0]  r_cnt;
    logic        r_kind_ads;
    logic        r_src;
    logic [47:0] r_asm;
    logic [15:0] r_tmo;
    logic [47:0] r_ads_data;
    logic        r_ads_vld;
    logic [15:0] r_reg_data;
    logic        r_reg_src;
    logic        r_reg_vld;
    logic        r_err;

    assign o_ADS_DATA  = r_ads_data;
    assign o_ADS_VALID = r_ads_vld;
    assign o_REG_DATA  = r_reg_data;
    assign o_REG_SRC   = r_reg_src;
    assign o_REG_VALID = r_reg_vld;
    assign o_ERR_PULSE = r_err;

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_state    <= PS_HUNT;
            r_need     <= '0;
            r_cnt      <= '0;
            r_kind_ads <= 1'b0;
            r_src      <= 1'b0;
            r_asm      <= '0;
            r_tmo      <= '0;
            r_ads_data <= '0;
            r_ads_vld  <= 1'b0;
            r_reg_data <= '0;
            r_reg_src  <= 1'b0;
            r_reg_vld  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ads_vld <= 1'b0;
            r_reg_vld <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                PS_HUNT: begin
                    r_tmo <= '0;
                    r_cnt <= '0;
                    if (i_RX_DV) begin
                        if (i_RX_BYTE == HDR_ADS) begin
                            r_need     <= LEN_ADS;
                            r_kind_ads <= 1'b1;
                            r_state    <= PS_COLLECT;
                        end else if (i_RX_BYTE == HDR_ADS_REG || i_RX_BYTE == HDR_MPR_REG) begin
                            r_need     <= LEN_REG;
                            r_kind_ads <= 1'b0;
                            r_src      <= (i_RX_BYTE == HDR_ADS_REG);
                            r_state    <= PS_COLLECT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    // Byte is checked first so it wins over a coincident timeout
                    if (i_RX_DV) begin
                        r_asm <= {r_asm[39:0], i_RX_BYTE};
                        r_tmo <= '0;
                        if (r_cnt + 3'd1 == r_need) begin
                            if (r_kind_ads) begin
                                r_ads_data <= {r_asm[39:0], i_RX_BYTE};
                                r_ads_vld  <= 1'b1;
                            end else begin
                                r_reg_data <= {r_asm[7:0], i_RX_BYTE};
                                r_reg_src  <= r_src;
                                r_reg_vld  <= 1'b1;
                            end
                            r_state <= PS_HUNT;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= PS_HUNT;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver byte engine; ports i_CLK/i_RSTN/i_RXD in, o_RX_DV/o_RX_BYTE out.
// Latency: o_RX_DV pulses one cycle at mid stop bit (~9.5 bit times after start edge + 2-flop sync).
// Backpressure: none; each byte is presented once and must be consumed that cycle.
module uart_rx #(
    parameter int P_CLKS_PER_BIT = 217
) (
    input  logic       i_CLK,
    input  logic       i_RSTN,
    input  logic       i_RXD,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_BYTE
);
    localparam int CW = $clog2(P_CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(P_CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((P_CLKS_PER_BIT - 1) / 2);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

    rx_state_e     r_state;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_byte;
    logic          r_dv;
    logic          w_rxd;

    assign w_rxd     = r_sync[1];
    assign o_RX_DV   = r_dv;
    assign o_RX_BYTE = r_byte;

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_state   <= R_IDLE;
            r_sync    <= 2'b11;
            r_clk_cnt <= '0;
            r_idx     <= '0;
            r_byte    <= '0;
            r_dv      <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_RXD};
            r_dv   <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    r_clk_cnt <= '0;
                    r_idx     <= '0;
                    if (!w_rxd) r_state <= R_START;
                end
                R_START: begin
                    // Re-check at mid start bit so a glitch does not start a byte
                    if (r_clk_cnt == HALF) begin
                        r_clk_cnt <= '0;
                        r_state   <= w_rxd ? R_IDLE : R_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_clk_cnt == FULL) begin
                        r_clk_cnt     <= '0;
                        r_byte[r_idx] <= w_rxd;
                        if (r_idx == 3'd7) r_state <= R_STOP;
                        else               r_idx   <= r_idx + 1'b1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_clk_cnt == FULL) begin
                        r_clk_cnt <= '0;
                        r_dv      <= w_rxd;   // framing error drops the byte
                        r_state   <= R_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_tx.sv
// Purpose: 8N1 UART transmitter byte engine; ports i_CLK/i_RSTN/i_TX_DV/i_TX_BYTE in, o_TXD/o_TX_DONE out.
// Latency: line goes low the cycle after i_TX_DV; o_TX_DONE pulses after 10 bit times.
// Backpressure: i_TX_DV is only honoured while idle; caller waits for o_TX_DONE.
module uart_tx #(
    parameter int P_CLKS_PER_BIT = 217
) (
    input  logic       i_CLK,
    input  logic       i_RSTN,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_BYTE,
    output logic       o_TXD,
    output logic       o_TX_DONE
);
    localparam int CW = $clog2(P_CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(P_CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_eng_state_e;

    tx_eng_state_e r_state;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_txd;
    logic          r_done;

    assign o_TXD     = r_txd;
    assign o_TX_DONE = r_done;

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_state   <= T_IDLE;
            r_clk_cnt <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                T_IDLE: begin
                    r_txd     <= 1'b1;
                    r_clk_cnt <= '0;
                    r_idx     <= '0;
                    if (i_TX_DV) begin
                        r_shift <= i_TX_BYTE;
                        r_txd   <= 1'b0;
                        r_state <= T_START;
                    end
                end
                T_START: begin
                    if (r_clk_cnt == FULL) begin
                        r_clk_cnt <= '0;
                        r_txd     <= r_shift[0];
                        r_state   <= T_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                T_DATA: begin
                    if (r_clk_cnt == FULL) begin
                        r_clk_cnt <= '0;
                        if (r_idx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= T_STOP;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_txd   <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_clk_cnt == FULL) begin
                        r_clk_cnt <= '0;
                        r_done    <= 1'b1;
                        r_state   <= T_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_host_bridge.sv
// Purpose: host-side UART bridge: command requests -> sensor byte sequences (TX), sensor frames -> parallel words (RX).
//   Ports: i_CLK/i_RSTN; i_UART_RXD/o_UART_TXD serial; i_CMD_VALID/OP/ADDR + o_CMD_READY command handshake;
//   o_ADS_DATA/VALID, o_REG_DATA/SRC/VALID frame outputs; o_ERR_CNT saturating error count.
// Latency: header starts 2 cycles after accept; READY returns the cycle after the final byte completes.
// Backpressure: o_CMD_READY low while a command is in flight; requests seen while low are ignored.
module uart_host_bridge
    import uart_host_bridge_pkg::*;
#(
    parameter int P_TIMEOUT_CLKS = 21700,
    parameter int P_ERR_CNT_W    = 8,
    parameter int P_CLKS_PER_BIT = 217
) (
    input  logic                   i_CLK,
    input  logic                   i_RSTN,
    input  logic                   i_UART_RXD,
    output logic                   o_UART_TXD,
    input  logic                   i_CMD_VALID,
    input  logic [1:0]             i_CMD_OP,
    input  logic [7:0]             i_CMD_ADDR,
    output logic                   o_CMD_READY,
    output logic [47:0]            o_ADS_DATA,
    output logic                   o_ADS_VALID,
    output logic [15:0]            o_REG_DATA,
    output logic                   o_REG_SRC,
    output logic                   o_REG_VALID,
    output logic [P_ERR_CNT_W-1:0] o_ERR_CNT
);
    logic       w_rx_dv;
    logic [7:0] w_rx_byte;
    logic       w_tx_done;
    logic       w_err_pulse;

    tx_state_e               r_tx_state;
    cmd_op_e                 r_op;
    logic [7:0]              r_addr;
    logic                    r_cmd_ready;
    logic                    r_tx_dv;
    logic [7:0]              r_tx_byte;
    logic [P_ERR_CNT_W-1:0]  r_err_cnt;

    assign o_CMD_READY = r_cmd_ready;
    assign o_ERR_CNT   = r_err_cnt;

    uart_rx #(.P_CLKS_PER_BIT(P_CLKS_PER_BIT)) u_rx (
        .i_CLK     (i_CLK),
        .i_RSTN    (i_RSTN),
        .i_RXD     (i_UART_RXD),
        .o_RX_DV   (w_rx_dv),
        .o_RX_BYTE (w_rx_byte)
    );

    uart_tx #(.P_CLKS_PER_BIT(P_CLKS_PER_BIT)) u_tx (
        .i_CLK     (i_CLK),
        .i_RSTN    (i_RSTN),
        .i_TX_DV   (r_tx_dv),
        .i_TX_BYTE (r_tx_byte),
        .o_TXD     (o_UART_TXD),
        .o_TX_DONE (w_tx_done)
    );

    uart_frame_parser #(.P_TIMEOUT_CLKS(P_TIMEOUT_CLKS)) u_parser (
        .i_CLK       (i_CLK),
        .i_RSTN      (i_RSTN),
        .i_RX_DV     (w_rx_dv),
        .i_RX_BYTE   (w_rx_byte),
        .o_ADS_DATA  (o_ADS_DATA),
        .o_ADS_VALID (o_ADS_VALID),
        .o_REG_DATA  (o_REG_DATA),
        .o_REG_SRC   (o_REG_SRC),
        .o_REG_VALID (o_REG_VALID),
        .o_ERR_PULSE (w_err_pulse)
    );

    // Command sequencer: ready comes up in IDLE one cycle after reset release
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_tx_state  <= TX_IDLE;
            r_op        <= OP_RUN;
            r_addr      <= '0;
            r_cmd_ready <= 1'b0;
            r_tx_dv     <= 1'b0;
            r_tx_byte   <= '0;
        end else begin
            r_tx_dv <= 1'b0;
            case (r_tx_state)
                TX_IDLE: begin
                    if (r_cmd_ready && i_CMD_VALID) begin
                        r_op        <= cmd_op_e'(i_CMD_OP);
                        r_addr      <= i_CMD_ADDR;
                        r_cmd_ready <= 1'b0;
                        r_tx_state  <= TX_SEND_HDR;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                TX_SEND_HDR: begin
                    r_tx_dv    <= 1'b1;
                    r_tx_byte  <= op_header(r_op);
                    r_tx_state <= TX_WAIT_HDR;
                end
                TX_WAIT_HDR: begin
                    if (w_tx_done) begin
                        if (op_has_addr(r_op)) begin
                            r_tx_state <= TX_SEND_ADDR;
                        end else begin
                            r_cmd_ready <= 1'b1;
                            r_tx_state  <= TX_IDLE;
                        end
                    end
                end
                TX_SEND_ADDR: begin
                    r_tx_dv    <= 1'b1;
                    r_tx_byte  <= r_addr;
                    r_tx_state <= TX_WAIT_ADDR;
                end
                TX_WAIT_ADDR: begin
                    if (w_tx_done) begin
                        r_cmd_ready <= 1'b1;
                        r_tx_state  <= TX_IDLE;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            r_err_cnt <= '0;
        end else if (w_err_pulse && (r_err_cnt != {P_ERR_CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + P_ERR_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_uart_host_bridge.sv
module tb_uart_host_bridge;
    localparam int CPB = 16;
    localparam int TMO = 400;
    localparam int EW  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rxd;
    logic          txd;
    logic          cmd_vld;
    logic [1:0]    cmd_op;
    logic [7:0]    cmd_addr;
    logic          cmd_rdy;
    logic [47:0]   ads_data;
    logic          ads_vld;
    logic [15:0]   reg_data;
    logic          reg_src;
    logic          reg_vld;
    logic [EW-1:0] err_cnt;

    always #5 clk = ~clk;

    uart_host_bridge #(
        .P_TIMEOUT_CLKS (TMO),
        .P_ERR_CNT_W    (EW),
        .P_CLKS_PER_BIT (CPB)
    ) dut (
        .i_CLK       (clk),
        .i_RSTN      (rst_n),
        .i_UART_RXD  (rxd),
        .o_UART_TXD  (txd),
        .i_CMD_VALID (cmd_vld),
        .i_CMD_OP    (cmd_op),
        .i_CMD_ADDR  (cmd_addr),
        .o_CMD_READY (cmd_rdy),
        .o_ADS_DATA  (ads_data),
        .o_ADS_VALID (ads_vld),
        .o_REG_DATA  (reg_data),
        .o_REG_SRC   (reg_src),
        .o_REG_VALID (reg_vld),
        .o_ERR_CNT   (err_cnt)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0]  exp_tx[$];
    logic [47:0] exp_ads[$];
    logic [16:0] exp_reg[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [63:0] act);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got %0h with nothing expected", nm, act);
    endtask

    // TX monitor: decodes TXD at mid-bit; a byte cut by reset is discarded
    logic       mon_prev = 1'b1;
    logic [7:0] mon_b;
    logic       mon_ok;
    initial begin : tx_mon
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && mon_prev && !txd) begin
                mon_ok = 1'b1;
                repeat (CPB/2) begin @(negedge clk); if (!rst_n) mon_ok = 1'b0; end
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(negedge clk); if (!rst_n) mon_ok = 1'b0; end
                    mon_b[i] = txd;
                end
                repeat (CPB) begin @(negedge clk); if (!rst_n) mon_ok = 1'b0; end
                if (mon_ok) begin
                    chk("tx_stop_bit", {63'd0, txd}, 64'd1);
                    if (exp_tx.size() == 0) unexpected("tx_byte_extra", {56'd0, mon_b});
                    else chk("tx_byte", {56'd0, mon_b}, {56'd0, exp_tx.pop_front()});
                end
            end
            mon_prev = txd;
        end
    end

    // Frame output monitor
    initial begin : rx_mon
        forever begin
            @(negedge clk);
            if (ads_vld && reg_vld) unexpected("both_valids", 64'd3);
            if (ads_vld) begin
                if (exp_ads.size() == 0) unexpected("ads_extra", {16'd0, ads_data});
                else chk("ads_data", {16'd0, ads_data}, {16'd0, exp_ads.pop_front()});
            end
            if (reg_vld) begin
                if (exp_reg.size() == 0) unexpected("reg_extra", {47'd0, reg_src, reg_data});
                else chk("reg_src_data", {47'd0, reg_src, reg_data}, {47'd0, exp_reg.pop_front()});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
        $fatal(1, "timeout");
    end

    task automatic rx_byte(input logic [7:0] b);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (CPB + 2) @(negedge clk);
    endtask

    // Holds valid until accepted; returns at the negedge after the accepting edge
    task automatic issue(input logic [1:0] op, input logic [7:0] addr);
        int waited;
        cmd_vld  = 1'b1;
        cmd_op   = op;
        cmd_addr = addr;
        waited   = 0;
        while (!cmd_rdy && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_rdy) unexpected("cmd_accept_timeout", 64'(waited));
        @(negedge clk);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!cmd_rdy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_rdy) unexpected("ready_timeout", 64'(n));
    endtask

    int busy;
    logic [7:0] seq_t3[7];
    logic [7:0] seq_t6[7];

    initial begin : stim
        rst_n    = 1'b0;
        rxd      = 1'b1;
        cmd_vld  = 1'b0;
        cmd_op   = 2'd0;
        cmd_addr = 8'd0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_txd", {63'd0, txd}, 64'd1);
        chk("rst_ready", {63'd0, cmd_rdy}, 64'd0);
        chk("rst_ads_data", {16'd0, ads_data}, 64'd0);
        chk("rst_reg_data", {48'd0, reg_data}, 64'd0);
        chk("rst_valids", {62'd0, ads_vld, reg_vld}, 64'd0);
        chk("rst_err", {56'd0, err_cnt}, 64'd0);
        rst_n = 1'b1;
        chk("ready_before_edge", {63'd0, cmd_rdy}, 64'd0);
        @(negedge clk);
        chk("ready_after_release", {63'd0, cmd_rdy}, 64'd1);

        // T1: ADS register read, addr 0x1C
        exp_tx.push_back(8'h61);
        exp_tx.push_back(8'h1C);
        issue(2'd3, 8'h1C);
        cmd_vld = 1'b0;
        chk("t1_ready_drop", {63'd0, cmd_rdy}, 64'd0);
        wait_ready(busy);
        chk("t1_busy_window", {63'd0, (busy >= 320 && busy <= 340)}, 64'd1);
        chk("t1_tx_drained", 64'(exp_tx.size()), 64'd0);

        // T2: RUN then STOP held on valid while busy
        exp_tx.push_back(8'h52);
        exp_tx.push_back(8'h93);
        issue(2'd0, 8'h00);
        chk("t2_ready_drop", {63'd0, cmd_rdy}, 64'd0);
        issue(2'd1, 8'h00);
        cmd_vld = 1'b0;
        chk("t2_run_sent_first", 64'(exp_tx.size()), 64'd1);
        wait_ready(busy);
        chk("t2_stop_single_byte", {63'd0, (busy >= 160 && busy <= 170)}, 64'd1);
        chk("t2_tx_drained", 64'(exp_tx.size()), 64'd0);

        // T3: ADS frame with 0xAA in payload
        seq_t3 = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'hAA, 8'hBC, 8'hDE};
        exp_ads.push_back(48'h123456AABCDE);
        foreach (seq_t3[i]) rx_byte(seq_t3[i]);
        repeat (5) @(negedge clk);
        chk("t3_ads_seen", 64'(exp_ads.size()), 64'd0);
        chk("t3_err", {56'd0, err_cnt}, 64'd0);

        // T4: MPR register read-back
        exp_reg.push_back({1'b0, 16'h007F});
        rx_byte(8'h6D); rx_byte(8'h00); rx_byte(8'h7F);
        repeat (5) @(negedge clk);
        chk("t4_reg_seen", 64'(exp_reg.size()), 64'd0);
        chk("t4_ads_held", {16'd0, ads_data}, {16'd0, 48'h123456AABCDE});

        // T5: bad header, timed-out partial frame, then a good 'a' frame
        rx_byte(8'h55);
        repeat (5) @(negedge clk);
        chk("t5_err_badhdr", {56'd0, err_cnt}, 64'd1);
        rx_byte(8'h61); rx_byte(8'hAB);
        repeat (TMO + 100) @(negedge clk);
        chk("t5_err_timeout", {56'd0, err_cnt}, 64'd2);
        exp_reg.push_back({1'b1, 16'h0102});
        rx_byte(8'h61); rx_byte(8'h01); rx_byte(8'h02);
        repeat (5) @(negedge clk);
        chk("t5_reg_seen", 64'(exp_reg.size()), 64'd0);
        chk("t5_err_final", {56'd0, err_cnt}, 64'd2);
        chk("t5_reg_out", {47'd0, reg_src, reg_data}, {47'd0, 1'b1, 16'h0102});

        // T6: reset mid ADS frame and mid TX byte
        rx_byte(8'hAA); rx_byte(8'h11); rx_byte(8'h22);
        issue(2'd2, 8'h33);
        cmd_vld = 1'b0;
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_rst_txd", {63'd0, txd}, 64'd1);
        chk("t6_rst_ready", {63'd0, cmd_rdy}, 64'd0);
        chk("t6_rst_valids", {62'd0, ads_vld, reg_vld}, 64'd0);
        chk("t6_rst_err", {56'd0, err_cnt}, 64'd0);
        chk("t6_rst_ads_data", {16'd0, ads_data}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_back", {63'd0, cmd_rdy}, 64'd1);
        seq_t6 = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        exp_ads.push_back(48'h010203040506);
        foreach (seq_t6[i]) rx_byte(seq_t6[i]);
        repeat (5) @(negedge clk);
        chk("t6_ads_seen", 64'(exp_ads.size()), 64'd0);
        chk("t6_err", {56'd0, err_cnt}, 64'd0);

        repeat (20) @(negedge clk);
        chk("end_tx_drained", 64'(exp_tx.size()), 64'd0);
        chk("end_reg_drained", 64'(exp_reg.size()), 64'd0);
        chk("end_txd_idle", {63'd0, txd}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
